// File: rtl/iter_shifter_pkg.sv
// Shared types for the iterative shifter.
// The op encoding is shared with the ALU decode.
package iter_shifter_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Width of a per-cycle shift count that spans 0..step.
    function automatic int step_k_w(input int step);
        return $clog2(step + 1);
    endfunction

endpackage

// File: rtl/iter_shifter_step.sv
// Combinational single-step shifter: moves data by k (0..STEP) bits.
// Carry is the last bit pushed out; ROR reports the new MSB.
module shift_step
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int KW    = step_k_w(STEP)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [KW-1:0]    k,
    input  shift_op_e        op,
    input  logic             sign,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0]        lsl_w;
    logic [STEP+WIDTH:0]   rs_w;
    logic [2*WIDTH-1:0]    ror_w;
    logic                  fill;

    // Extended vectors keep the outgoing bit next to the result.
    always_comb begin
        fill   = (op == OP_ASR) ? sign : 1'b0;
        lsl_w  = {1'b0, data} << k;
        rs_w   = {{STEP{fill}}, data, 1'b0} >> k;
        ror_w  = {data, data} >> k;
        result = data;
        carry  = 1'b0;
        unique case (op)
            OP_LSL: begin
                result = lsl_w[WIDTH-1:0];
                carry  = lsl_w[WIDTH];
            end
            OP_LSR, OP_ASR: begin
                result = rs_w[WIDTH:1];
                carry  = rs_w[0];
            end
            OP_ROR: begin
                result = ror_w[WIDTH-1:0];
                carry  = ror_w[WIDTH-1];
            end
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: up to STEP bit positions per clock.
// Valid/ready on both sides; results held in DONE until taken.
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry,
    output logic               busy
);

    localparam int KW = step_k_w(STEP);

    state_e             state;
    state_e             state_d;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] remaining;
    shift_op_e          op_q;
    logic               sign;
    logic [KW-1:0]      k;
    logic               last_step;
    logic [WIDTH-1:0]   step_data;
    logic               step_carry;
    logic               accept;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Per-cycle step size is min(remaining, STEP).
    always_comb begin
        k         = '0;
        last_step = 1'b1;
        if (int'(remaining) > STEP) begin
            k         = KW'(STEP);
            last_step = 1'b0;
        end else begin
            k         = KW'(remaining);
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .data   (work),
        .k      (k),
        .op     (op_q),
        .sign   (sign),
        .result (step_data),
        .carry  (step_carry)
    );

    // Next-state logic; zero shifts skip straight to DONE.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (accept)
                         state_d = (in_shamt == '0) ? DONE : SHIFT;
            SHIFT:   if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Working operand, countdown and held result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            work      <= '0;
            remaining <= '0;
            op_q      <= OP_LSL;
            sign      <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
        end else if (accept) begin
            work      <= in_data;
            remaining <= in_shamt;
            op_q      <= shift_op_e'(in_op);
            sign      <= in_data[WIDTH-1];
            if (in_shamt == '0) begin
                out_data  <= in_data;
                out_carry <= 1'b0;
            end
        end else if (state == SHIFT) begin
            work      <= step_data;
            remaining <= remaining - SHAMT_W'(k);
            if (last_step) begin
                out_data  <= step_data;
                out_carry <= step_carry;
            end
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter (WIDTH=16, STEP=4),
// plus a short directed run on a STEP=1 instance.
module tb_iter_shifter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] in_data   = '0;
    logic [3:0]  in_shamt  = '0;
    logic [1:0]  in_op     = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_carry;
    logic        busy;

    logic        b_reset     = 1'b1;
    logic        b_in_valid  = 1'b0;
    logic        b_in_ready;
    logic [15:0] b_in_data   = '0;
    logic [3:0]  b_in_shamt  = '0;
    logic [1:0]  b_in_op     = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [15:0] b_out_data;
    logic        b_out_carry;
    logic        b_busy;

    iter_shifter #(.WIDTH(16), .STEP(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry), .busy(busy)
    );

    iter_shifter #(.WIDTH(16), .STEP(1)) dut1 (
        .clk(clk), .reset(b_reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_shamt(b_in_shamt), .in_op(b_in_op),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_carry(b_out_carry), .busy(b_busy)
    );

    typedef struct {
        logic [15:0] d;
        logic        c;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    exp_t held;
    int   checks   = 0;
    int   passes   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    bit   shown    = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: whole shift at once from the operand and amount.
    function automatic void model(input logic [1:0] op,
                                  input logic [15:0] d, input int s,
                                  output logic [15:0] r, output logic c);
        if (s == 0) begin
            r = d;
            c = 1'b0;
        end else begin
            case (op)
                2'd0: begin r = d << s; c = d[16-s]; end
                2'd1: begin r = d >> s; c = d[s-1]; end
                2'd2: begin r = 16'($signed(d) >>> s); c = d[s-1]; end
                default: begin
                    r = (d >> s) | (d << (16 - s));
                    c = r[15];
                end
            endcase
        end
    endfunction

    // Monitor: pops expected results when out_valid rises.
    always @(negedge clk) begin
        cyc++;
        if (in_valid && in_ready && !reset) acc_cyc = cyc;
        if (out_valid) begin
            if (!shown) begin
                shown = 1;
                if (sbq.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                    held.d = out_data;
                    held.c = out_carry;
                end else begin
                    held = sbq.pop_front();
                    check("data", 32'(out_data), 32'(held.d));
                    check("carry", 32'(out_carry), 32'(held.c));
                    check("latency", 32'(cyc - acc_cyc), 32'(held.lat));
                end
            end else begin
                check("stable_data", 32'(out_data), 32'(held.d));
                check("stable_carry", 32'(out_carry), 32'(held.c));
            end
            check("in_ready_in_done", 32'(in_ready), 32'd0);
            if (out_ready) begin
                shown = 0;
                done_cnt++;
            end
        end
    end

    // mode 0: out_ready high, 1: random, 2: stall 3 cycles in DONE
    task automatic run(input logic [1:0] op, input logic [15:0] d,
                       input int s, input int mode);
        exp_t        e;
        logic [15:0] r;
        logic        c;
        int          start;
        int          t;
        int          vcnt;
        model(op, d, s, r, c);
        e.d   = r;
        e.c   = c;
        e.lat = (s + 3) / 4 + 1;
        @(posedge clk) #1;
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = 4'(s);
        in_op     = op;
        out_ready = (mode == 0);
        sbq.push_back(e);
        start = done_cnt;
        t     = 0;
        vcnt  = 0;
        @(posedge clk) #1;
        while (done_cnt == start && t < 100) begin
            in_valid = 1'($urandom);
            in_data  = 16'($urandom);
            in_shamt = 4'($urandom);
            in_op    = 2'($urandom);
            if (out_valid) vcnt++;
            if (mode == 1) out_ready = 1'($urandom);
            else if (mode == 2) out_ready = (vcnt > 3);
            @(posedge clk) #1;
            t++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (t >= 100) begin
            check("timeout", 32'd0, 32'd1);
            sbq.delete();
            reset = 1'b1;
            @(posedge clk) #1;
            reset = 1'b0;
            shown = 0;
        end else begin
            check("in_ready_after", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int lat;
        @(posedge clk) #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        run(2'd0, 16'h00F1, 4, 0);
        run(2'd2, 16'h8010, 5, 0);
        run(2'd3, 16'h1234, 8, 0);
        run(2'd1, 16'h1234, 15, 0);
        run(2'd1, 16'hABCD, 0, 0);
        run(2'd2, 16'h8001, 15, 0);
        run(2'd0, 16'h8001, 15, 0);
        run(2'd3, 16'h0001, 1, 0);
        run(2'd2, 16'h9ABC, 7, 2);

        @(posedge clk) #1;
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        in_shamt = 4'd12;
        in_op    = 2'd0;
        @(posedge clk) #1;
        in_valid = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_out_data", 32'(out_data), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        run(2'd0, 16'h00F1, 4, 0);

        for (int i = 0; i < 80; i++) begin
            run(2'($urandom), 16'($urandom), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 1)));
        end
        check("queue_empty", 32'(sbq.size()), 32'd0);

        @(posedge clk) #1;
        b_reset = 1'b0;
        b_in_valid = 1'b1;
        b_in_data  = 16'h8010;
        b_in_shamt = 4'd5;
        b_in_op    = 2'd2;
        @(posedge clk) #1;
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 30) begin
            @(posedge clk) #1;
            lat++;
        end
        check("s1_latency", 32'(lat), 32'd6);
        check("s1_data", 32'(b_out_data), 32'h0000_FC00);
        check("s1_carry", 32'(b_out_carry), 32'd1);
        @(posedge clk) #1;
        check("s1_in_ready", 32'(b_in_ready), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
